// File: rtl/mdio_controller.sv
// mdio_controller: clause-22 MDIO master with CLK/2 MDC, preamble, write frames and read capture
module mdio_controller #(
  parameter int PRE_LEN = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_WR_TAIL  = 3'd3;
  localparam logic [2:0] S_RD_TA    = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [5:0] PRE        = 6'(PRE_LEN);
  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [31:0] sr;
  logic [1:0]  op;
  logic [14:0] rx;
  // MDC=1 before an edge means this edge is an MDC falling edge (drive); MDC=0 means rising (sample)
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      MDC      <= 1'b0;
      MDIO_OE  <= 1'b0;
      MDIO_OUT <= 1'b0;
      RD_DATA  <= 16'h0000;
      DATA_RDY <= 1'b0;
      BUSY     <= 1'b0;
      state    <= S_IDLE;
      cnt      <= 6'd0;
      sr       <= 32'h0;
      op       <= 2'b00;
      rx       <= 15'h0;
    end else begin
      MDC      <= ~MDC;
      DATA_RDY <= 1'b0;
      if (state == S_IDLE) begin
        if (MDIO_START) begin
          sr    <= T_DATA;
          op    <= T_DATA[29:28];
          BUSY  <= 1'b1;
          state <= (PRE == 6'd0) ? S_HEADER : S_PREAMBLE;
          cnt   <= (PRE == 6'd0) ? 6'd14 : PRE;
        end
      end else if (MDC) begin
        case (state)
          S_PREAMBLE: begin
            MDIO_OE  <= 1'b1;
            MDIO_OUT <= 1'b1;
            state    <= (cnt == 6'd1) ? S_HEADER : S_PREAMBLE;
            cnt      <= (cnt == 6'd1) ? 6'd14 : cnt - 6'd1;
          end
          S_HEADER: begin
            MDIO_OE  <= 1'b1;
            MDIO_OUT <= sr[31];
            sr       <= {sr[30:0], 1'b0};
            state    <= (cnt != 6'd1) ? S_HEADER : (op == 2'b10) ? S_RD_TA : S_WR_TAIL;
            cnt      <= (cnt != 6'd1) ? cnt - 6'd1 : (op == 2'b10) ? 6'd2 : 6'd18;
          end
          S_WR_TAIL: begin
            MDIO_OE  <= 1'b1;
            MDIO_OUT <= sr[31];
            sr       <= {sr[30:0], 1'b0};
            state    <= (cnt == 6'd1) ? S_DONE : S_WR_TAIL;
            cnt      <= (cnt == 6'd1) ? 6'd0 : cnt - 6'd1;
          end
          // two turnaround periods, then the third falling edge opens data period one
          S_RD_TA: begin
            MDIO_OE  <= 1'b0;
            MDIO_OUT <= 1'b0;
            state    <= (cnt == 6'd0) ? S_RD_DATA : S_RD_TA;
            cnt      <= (cnt == 6'd0) ? 6'd16 : cnt - 6'd1;
          end
          S_DONE: begin
            MDIO_OE  <= 1'b0;
            MDIO_OUT <= 1'b0;
            BUSY     <= 1'b0;
            state    <= S_IDLE;
            cnt      <= 6'd0;
          end
          default: ;
        endcase
      end else if (state == S_RD_DATA) begin
        rx  <= {rx[13:0], MDIO_IN};
        cnt <= (cnt == 6'd1) ? 6'd0 : cnt - 6'd1;
        if (cnt == 6'd1) begin
          RD_DATA  <= {rx, MDIO_IN};
          DATA_RDY <= 1'b1;
          state    <= S_DONE;
        end
      end
    end
endmodule

// File: tb/tb_mdio_controller.sv
// tb_mdio_controller: directed checks of write, read, ignore-while-busy, back-to-back and reset abort
module tb_mdio_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] T_DATA = 32'h0;
  logic        MDIO_IN = 1'b0;
  logic        st32 = 1'b0, st0 = 1'b0;
  logic        sel = 1'b0;
  logic        mdc32, oe32, out32, rdy32, busy32;
  logic        mdc0, oe0, out0, rdy0, busy0;
  logic [15:0] rd32, rd0;
  logic        mdc_s, oe_s, out_s, rdy_s, busy_s;
  logic [15:0] rd_s;
  int          n_chk = 0, n_fail = 0, rdy_n = 0, blow_n = 0;
  logic [63:0] outs, oes;
  logic [31:0] td;

  mdio_controller #(.PRE_LEN(32)) u32 (
    .CLK(CLK), .RESET(RESET), .MDIO_START(st32), .T_DATA(T_DATA), .MDIO_IN(MDIO_IN),
    .MDC(mdc32), .MDIO_OE(oe32), .MDIO_OUT(out32), .RD_DATA(rd32), .DATA_RDY(rdy32), .BUSY(busy32)
  );
  mdio_controller #(.PRE_LEN(0)) u0 (
    .CLK(CLK), .RESET(RESET), .MDIO_START(st0), .T_DATA(T_DATA), .MDIO_IN(MDIO_IN),
    .MDC(mdc0), .MDIO_OE(oe0), .MDIO_OUT(out0), .RD_DATA(rd0), .DATA_RDY(rdy0), .BUSY(busy0)
  );

  assign mdc_s  = sel ? mdc0  : mdc32;
  assign oe_s   = sel ? oe0   : oe32;
  assign out_s  = sel ? out0  : out32;
  assign rdy_s  = sel ? rdy0  : rdy32;
  assign busy_s = sel ? busy0 : busy32;
  assign rd_s   = sel ? rd0   : rd32;

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) st0 = v;
    else st32 = v;
  endtask

  task automatic fall();
    int k;
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
      if (rdy_s) rdy_n++;
      if (!busy_s) blow_n++;
    end while (mdc_s !== 1'b0 && k < 4);
    if (mdc_s !== 1'b0) chk("mdc_fall_timeout", {63'h0, mdc_s}, 64'h0);
  endtask

  task automatic start(input logic [31:0] d);
    T_DATA = d;
    set_start(1'b1);
    @(posedge CLK); #1;
    chk("busy_on_accept", {63'h0, busy_s}, 64'h1);
  endtask

  task automatic run(input int n, input bit rd, input logic [15:0] w, input int inj,
                     input logic [31:0] itd, input int clr,
                     output logic [63:0] o, output logic [63:0] e);
    o = 64'h0; e = 64'h0; rdy_n = 0; blow_n = 0;
    for (int p = 1; p <= n; p++) begin
      fall();
      o = {o[62:0], out_s};
      e = {e[62:0], oe_s};
      if (rd && p >= 17) MDIO_IN = w[32-p];
      if (p == inj) begin T_DATA = itd; set_start(1'b1); end
      if (p == clr) set_start(1'b0);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_u32"}, {43'h0, mdc32, oe32, out32, rdy32, busy32, rd32}, 64'h0);
    chk({tag, "_u0"},  {43'h0, mdc0, oe0, out0, rdy0, busy0, rd0}, 64'h0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 rst_chk("reset_state");
    @(negedge CLK) RESET = 1'b0;
    @(posedge CLK); #1;
    chk("mdc_after_release", {63'h0, mdc32}, 64'h1);
    // write with a stray start/data change mid-frame that must be ignored
    sel = 1'b0;
    start(32'h58A61234);
    set_start(1'b0);
    run(64, 1'b0, 16'h0, 40, 32'hDEADBEEF, 41, outs, oes);
    chk("wr_stream", outs, 64'hFFFFFFFF_58A61234);
    chk("wr_oe", oes, 64'hFFFFFFFF_FFFFFFFF);
    chk("wr_no_rdy", rdy_n, 0);
    chk("wr_busy_held", {63'h0, busy_s}, 64'h1);
    fall();
    chk("wr_done_busy", {63'h0, busy_s}, 64'h0);
    chk("wr_done_oe_out", {62'h0, oe_s, out_s}, 64'h0);
    chk("wr_rd_data", rd_s, 64'h0);
    // read, PRE_LEN=0; MDIO_IN held 1 through header and turnaround
    sel = 1'b1;
    MDIO_IN = 1'b1;
    start(32'h68A00000);
    set_start(1'b0);
    run(32, 1'b1, 16'hBEEF, 0, 32'h0, 0, outs, oes);
    chk("rd_stream", outs, 64'h68A00000);
    chk("rd_oe", oes, 64'hFFFC0000);
    chk("rd_no_early_rdy", rdy_n, 0);
    @(posedge CLK); #1;
    chk("rd_rdy_pulse", {63'h0, rdy_s}, 64'h1);
    chk("rd_data", rd_s, 64'hBEEF);
    @(posedge CLK); #1;
    chk("rd_rdy_one_cycle", {63'h0, rdy_s}, 64'h0);
    chk("rd_busy_drop", {63'h0, busy_s}, 64'h0);
    // OP=11 is treated as a write and leaves RD_DATA alone
    td = {2'b01, 2'b11, 5'd3, 5'd9, 2'b10, 16'hA5C3};
    start(td);
    set_start(1'b0);
    run(32, 1'b0, 16'h0, 0, 32'h0, 0, outs, oes);
    chk("op11_stream", outs, {32'h0, td});
    chk("op11_oe", oes, 64'hFFFFFFFF);
    chk("op11_no_rdy", rdy_n, 0);
    fall();
    chk("op11_busy_drop", {63'h0, busy_s}, 64'h0);
    chk("op11_rd_data_kept", rd_s, 64'hBEEF);
    // back-to-back writes with MDIO_START held high
    sel = 1'b0;
    start(32'h51234ABC);
    run(64, 1'b0, 16'h0, 10, 32'h5ACE0F0F, 0, outs, oes);
    chk("b2b_first", outs, 64'hFFFFFFFF_51234ABC);
    fall();
    chk("b2b_gap_busy", {63'h0, busy_s}, 64'h0);
    chk("b2b_gap_oe", {63'h0, oe_s}, 64'h0);
    run(64, 1'b0, 16'h0, 0, 32'h0, 5, outs, oes);
    chk("b2b_second", outs, 64'hFFFFFFFF_5ACE0F0F);
    chk("b2b_second_oe", oes, 64'hFFFFFFFF_FFFFFFFF);
    chk("b2b_busy_continuous", blow_n, 0);
    fall();
    fall();
    chk("b2b_no_third", {63'h0, busy_s}, 64'h0);
    // reset asserted during read data bit 8
    sel = 1'b1;
    MDIO_IN = 1'b1;
    start(32'h68A00000);
    set_start(1'b0);
    run(24, 1'b1, 16'hBEEF, 0, 32'h0, 0, outs, oes);
    #3 RESET = 1'b1;
    #1 rst_chk("async_reset_abort");
    rdy_n = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (rdy0) rdy_n++;
    end
    chk("reset_no_rdy", rdy_n, 0);
    chk("reset_hold_mdc", {63'h0, mdc0}, 64'h0);
    @(negedge CLK) RESET = 1'b0;
    @(posedge CLK); #1;
    chk("reset_release_mdc", {63'h0, mdc0}, 64'h1);
    rdy_n = 0; blow_n = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (rdy0) rdy_n++;
      if (!busy0) blow_n++;
    end
    chk("post_reset_no_rdy", rdy_n, 0);
    chk("post_reset_idle", blow_n, 40);
    chk("post_reset_rd_data", rd0, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
